// File: rtl/flick_conditioner.sv
// -----------------------------------------------------------------------------
// flick_conditioner
//
// Input conditioner for the bound_flasher "flick" control. A raw, bouncing,
// asynchronous push-button is brought into the clk domain through a two-flop
// synchroniser. It is then debounced with a consecutive-sample counter and
// presented as a clean registered level plus a one-cycle press strobe.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronised samples that must disagree with
//                     flick before flick changes (1..65535)
//   REPEAT_CYCLES   : auto-repeat period while held (2..65535); only used when
//                     FLICK_REPEAT_EN is defined
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset; release is synchronous to clk
//   btn_raw     : raw button, asynchronous, may bounce
//   flick       : debounced level, registered
//   flick_pulse : registered one-cycle strobe per accepted press (and repeats)
//   bouncing    : high while the debounce counter is non-zero
//
// Optional feature
//   FLICK_REPEAT_EN : when defined, flick_pulse also fires every REPEAT_CYCLES
//                     cycles while the button stays held.
// -----------------------------------------------------------------------------
module flick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic flick,
    output logic flick_pulse,
    output logic bouncing
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // State is not stored separately: it is the pair (flick, db_cnt != 0).
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        HELD      = 2'b10,
        RELEASING = 2'b11
    } state_t;

    logic            s0;
    logic            s1;
    logic            sync;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            flick_nxt;
    logic            pulse_nxt;
    state_t          state;

`ifdef FLICK_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
`else
    // The repeat period has no function without auto-repeat.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYCLES != 0);
`endif

    // ---- synchroniser: btn_raw -> s0 -> s1 (no logic in between) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= btn_raw;
            s1 <= s0;
        end
    end

    assign sync     = s1;
    assign state    = state_t'({flick, (db_cnt != '0)});
    assign bouncing = (db_cnt != '0);

    // ---- debounce / press-detect next state ----
    always_comb begin
        db_cnt_nxt = '0;
        flick_nxt  = flick;
        pulse_nxt  = 1'b0;
`ifdef FLICK_REPEAT_EN
        rpt_cnt_nxt = '0;
`endif
        case (state)
            IDLE, ARMING: begin
                // Any 0 sample drops the count back to zero (default).
                if (sync) begin
                    if (db_cnt == DB_LAST) begin
                        flick_nxt = 1'b1;
                        pulse_nxt = 1'b1;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
            end
            HELD, RELEASING: begin
                if (!sync) begin
                    // Releases never strobe flick_pulse.
                    if (db_cnt == DB_LAST) begin
                        flick_nxt = 1'b0;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
`ifdef FLICK_REPEAT_EN
                // Repeat count advances only in steady HELD; a return from
                // RELEASING lands here with the count already cleared.
                else if (state == HELD) begin
                    if (rpt_cnt == RPT_LAST) begin
                        pulse_nxt = 1'b1;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                    end
                end
`endif
            end
            default: ;
        endcase
    end

    // ---- state / output registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt      <= '0;
            flick       <= 1'b0;
            flick_pulse <= 1'b0;
        end else begin
            db_cnt      <= db_cnt_nxt;
            flick       <= flick_nxt;
            flick_pulse <= pulse_nxt;
        end
    end

`ifdef FLICK_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
        end
    end
`endif

endmodule

// File: doc/flick_conditioner.md
# flick_conditioner

Input conditioner for the bound_flasher's `flick` control. Takes a raw, asynchronous, bouncing push-button signal and synchronises it into `clk`. Debounces it with a consecutive-sample counter and drives a clean `flick` level plus a one-cycle press pulse. Sits directly upstream of bound_flasher; its `flick` output connects to bound_flasher's `flick` input on the same `clk`/`rst_n`.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised samples that must disagree with the current `flick` before `flick` changes; legal range 1..65535.
- `REPEAT_CYCLES`, 8: period in cycles of auto-repeat pulses while held; legal range 2..65535; used only with `FLICK_REPEAT_EN`.
- `clk` input 1: single system clock, rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low; clears all state immediately, release is synchronous to `clk`.
- `btn_raw` input 1: raw button, asynchronous to `clk`, may bounce.
- `flick` output 1: debounced level, registered; feeds bound_flasher.
- `flick_pulse` output 1: registered one-cycle strobe on each accepted press (and repeats, if enabled).
- `bouncing` output 1: high while the debounce counter is non-zero (for debug/LED).

## Operation
- Synchroniser: two flops `s0`,`s1` clocked by `clk`, both reset to 0. `sync = s1`. No logic between `s0` and `s1`.
- Debounce counter `db_cnt` has width `$clog2(DEBOUNCE_CYCLES+1)` and resets to 0.
  - Each edge with `sync == flick`: `db_cnt <= 0`.
  - Each edge with `sync != flick` and `db_cnt == DEBOUNCE_CYCLES-1`: `flick <= sync`, `db_cnt <= 0`.
  - Otherwise: `db_cnt <= db_cnt + 1`. The counter never wraps.
- The state machine is encoded as (`flick`, `db_cnt != 0`):
  - IDLE (0, 0): goes to ARMING when `sync = 1`. With D = 1 it goes straight to HELD.
  - ARMING (0, counting): returns to IDLE on any `sync = 0` sample. Goes to HELD on the D-th consecutive 1.
  - HELD (1, 0): goes to RELEASING when `sync = 0`.
  - RELEASING (1, counting): returns to HELD on any `sync = 1` sample. Goes to IDLE on the D-th consecutive 0.
- `flick_pulse` is high for exactly the first cycle in which `flick = 1` after an IDLE/ARMING→HELD transition. A release never pulses.
- `bouncing` = `db_cnt != 0`, registered as part of state; no extra latency.
- Reset mid-operation: all outputs drop to 0 asynchronously. After release the block is in IDLE. A button still held at release is re-debounced from scratch and produces a fresh pulse.
- Reset values: `flick = 0`, `flick_pulse = 0`, `bouncing = 0`, `s0 = s1 = 0`, `db_cnt = 0`, repeat counter 0.

## Timing
- Assume `btn_raw` is stable high before edge k and was previously low in IDLE.
  - `sync = 1` after edge k+1.
  - `flick = 1` and `flick_pulse = 1` after edge k+1+D.
  - Total latency is D+2 rising edges.
- Release is symmetric: `flick = 0` after edge k+1+D. `flick_pulse` stays 0.
- `flick_pulse` drops after the following edge, so its width is exactly 1 cycle.
- Glitches shorter than D synchronised samples never change `flick`.
- A single disagreeing sample resets `db_cnt` to 0 on the next agreeing sample.
- Output-to-output: `flick` and `flick_pulse` rise on the same edge. bound_flasher sees `flick` one cycle later through its own input register, if it has one. This block makes no combinational path from `btn_raw`.

## Configuration
- Macro `FLICK_REPEAT_EN`.
- Defined: a repeat counter (width `$clog2(REPEAT_CYCLES+1)`) runs only in HELD.
  - It clears on the press pulse and on leaving HELD, including entry to RELEASING.
  - Each time it reaches `REPEAT_CYCLES-1`, it pulses `flick_pulse` for one cycle and clears.
  - Repeat pulses therefore occur every `REPEAT_CYCLES` cycles after the press pulse while held.
  - A return from RELEASING to HELD restarts the count without pulsing.
- Not defined: no repeat counter is synthesised and `REPEAT_CYCLES` is ignored. There is exactly one `flick_pulse` per accepted press.

## Test plan
- Reset/idle: `rst_n = 0` at 2 ns, release at 8 ns, `btn_raw = 0` → `flick`, `flick_pulse` and `bouncing` stay 0 for 300 ns.
- Clean press with D = 4 and 10 ns clock: `btn_raw` rises just after edge k and is held → `flick` rises after edge k+6. `flick_pulse` is high for exactly one cycle on that same edge. `bouncing` is high for the 3 preceding cycles.
- Bounce: toggle `btn_raw` 1/0 at 1-cycle intervals for 6 cycles, then hold 1 → no `flick` change during the bounce. `flick` rises 6 edges after the final stable 1, and exactly one `flick_pulse` occurs.
- Release with bounce: from HELD, a 2-cycle low glitch then high → `flick` stays 1 with no pulse. A clean low for 6+ cycles → `flick` falls 6 edges after the low and `flick_pulse` stays 0.
- Reset mid-press: assert `rst_n = 0` during ARMING (`db_cnt = 2`) and during HELD → outputs go to 0 within the reset pulse, before any clock edge. After release with `btn_raw` still 1, `flick` rises D+2 edges later with one new pulse.
- `FLICK_REPEAT_EN` with REPEAT_CYCLES = 8: hold the button for 40 cycles after `flick` rises → pulses at +0, +8, +16, +24, +32. Without the macro → a single pulse at +0.
